pipelined_funnel_shifter: RTL and testbench

//  Parametrised, pipelined funnel shifter: 2*DATA_W-bit input word, DATA_W-bit result window.

---
 rtl/funnel_pkg.sv | 17 +
 rtl/funnel_stage.sv | 86 ++++++++
 rtl/pipelined_funnel_shifter.sv | 90 +++++++++
 tb/tb_pipelined_funnel_shifter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/funnel_pkg.sv
// Shared types and helpers for the pipelined funnel shifter.
// Shift-mode encoding and the shift-amount width derivation.
package funnel_pkg;

    typedef enum logic [1:0] {
        LSR = 2'd0,
        ROR = 2'd1,
        ASR = 2'd2,
        LSL = 2'd3
    } shift_mode_e;

    // Shift-amount width for a DATA_W result (input word is 2*DATA_W).
    function automatic int shamt_w(int data_w);
        return $clog2(2 * data_w);
    endfunction

endpackage

// File: rtl/funnel_stage.sv
// One log2 shift level of the funnel shifter plus its register slice.
// Sticky tracking ports exist only when FUNNEL_STICKY_EN is defined.
module funnel_stage
    import funnel_pkg::*;
#(
    parameter  int W2    = 16,
    parameter  int SHIFT = 1,
    localparam int SW    = $clog2(W2),
    localparam int K     = $clog2(SHIFT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          in_valid,
    input  logic [W2-1:0] in_word,
    input  logic [SW-1:0] in_shamt,
    input  shift_mode_e   in_mode,
`ifdef FUNNEL_STICKY_EN
    input  logic          in_sticky,
    output logic          out_sticky,
`endif
    output logic          out_valid,
    output logic [W2-1:0] out_word,
    output logic [SW-1:0] out_shamt,
    output shift_mode_e   out_mode
);

    logic [W2-1:0] shifted;

    // Apply this level's shift when its shift-amount bit is set.
    always_comb begin
        shifted = in_word;
        if (in_shamt[K]) begin
            unique case (in_mode)
                LSR: shifted = in_word >> SHIFT;
                ROR: shifted = {in_word[SHIFT-1:0], in_word[W2-1:SHIFT]};
                ASR: shifted = W2'($signed(in_word) >>> SHIFT);
                LSL: shifted = in_word << SHIFT;
            endcase
        end
    end

`ifdef FUNNEL_STICKY_EN
    logic sticky_next;

    // Accumulate 1-bits dropped below bit 0 on right shifts that fill or zero.
    always_comb begin
        sticky_next = in_sticky;
        if (in_shamt[K] && (in_mode == LSR || in_mode == ASR)) begin
            sticky_next = in_sticky | (|in_word[SHIFT-1:0]);
        end
    end

    // Sticky bit travels with its item; held on stall or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sticky <= 1'b0;
        end else if (en && !clr) begin
            out_sticky <= sticky_next;
        end
    end
`endif

    // Valid is cleared by reset or flush; payload only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_shamt <= '0;
            out_mode  <= LSR;
        end else begin
            if (clr) begin
                out_valid <= 1'b0;
            end else if (en) begin
                out_valid <= in_valid;
            end
            if (en && !clr) begin
                out_word  <= shifted;
                out_shamt <= in_shamt;
                out_mode  <= in_mode;
            end
        end
    end

endmodule

// File: rtl/pipelined_funnel_shifter.sv
// Pipelined funnel shifter: 2*DATA_W word in, DATA_W window out, one level per stage.
// Optional sticky output enabled by defining FUNNEL_STICKY_EN.
module pipelined_funnel_shifter
    import funnel_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = shamt_w(DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_data,
    input  logic [SHAMT_W-1:0]  in_shamt,
    input  logic [1:0]          in_mode,
`ifdef FUNNEL_STICKY_EN
    output logic                out_sticky,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data
);

    localparam int W2 = 2 * DATA_W;

    logic              valid_q [0:SHAMT_W];
    logic [W2-1:0]     word_q  [0:SHAMT_W];
    logic [SHAMT_W-1:0] shamt_q [0:SHAMT_W];
    shift_mode_e       mode_q  [0:SHAMT_W];
`ifdef FUNNEL_STICKY_EN
    logic              sticky_q [0:SHAMT_W];
`endif

    logic adv;
    logic [SHAMT_W-1:0] unused_shamt;

    // Whole pipe moves together; a held result stalls every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv || flush;

    assign valid_q[0] = in_valid;
    assign word_q[0]  = in_data;
    assign shamt_q[0] = in_shamt;
    assign mode_q[0]  = shift_mode_e'(in_mode);
`ifdef FUNNEL_STICKY_EN
    assign sticky_q[0] = 1'b0;
`endif

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        funnel_stage #(
            .W2    (W2),
            .SHIFT (1 << k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .clr        (flush),
            .en         (adv),
            .in_valid   (valid_q[k]),
            .in_word    (word_q[k]),
            .in_shamt   (shamt_q[k]),
            .in_mode    (mode_q[k]),
`ifdef FUNNEL_STICKY_EN
            .in_sticky  (sticky_q[k]),
            .out_sticky (sticky_q[k+1]),
`endif
            .out_valid  (valid_q[k+1]),
            .out_word   (word_q[k+1]),
            .out_shamt  (shamt_q[k+1]),
            .out_mode   (mode_q[k+1])
        );
    end

    assign unused_shamt = shamt_q[SHAMT_W];

    // Left shifts expose the upper half of the word, all others the lower.
    always_comb begin
        out_valid = valid_q[SHAMT_W];
        if (mode_q[SHAMT_W] == LSL) begin
            out_data = word_q[SHAMT_W][W2-1:DATA_W];
        end else begin
            out_data = word_q[SHAMT_W][DATA_W-1:0];
        end
    end

`ifdef FUNNEL_STICKY_EN
    assign out_sticky = sticky_q[SHAMT_W];
`endif

endmodule

// File: tb/tb_pipelined_funnel_shifter.sv
// Scoreboard bench for pipelined_funnel_shifter (DATA_W=8).
// Define FUNNEL_STICKY_EN to also check the sticky output.
module tb_pipelined_funnel_shifter;

    localparam int DW = 8;
    localparam int W2 = 16;
    localparam int SW = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
    } exp_t;

    logic          clk = 0;
    logic          rst = 1;
    logic          flush = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [W2-1:0] in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [1:0]    in_mode = '0;
    logic          out_valid;
    logic          out_ready = 1;
    logic [DW-1:0] out_data;
    logic          sticky;

    exp_t exp_q[$];
    int   tot = 0;
    int   pass = 0;
    int   delivered = 0;
    bit   saw_stall = 0;
    bit   prev_hold = 0;
    logic [DW-1:0] held_data;
    bit   rand_done = 0;

    pipelined_funnel_shifter #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_mode    (in_mode),
`ifdef FUNNEL_STICKY_EN
        .out_sticky (sticky),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

`ifndef FUNNEL_STICKY_EN
    assign sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: whole-amount shift with plain arithmetic on the full word.
    function automatic exp_t model(input logic [W2-1:0] w, input int n,
                                   input logic [1:0] m);
        exp_t e;
        logic [2*W2-1:0] dbl;
        logic [W2-1:0] r;
        logic [31:0] mask;
        case (m)
            2'd0: r = w >> n;
            2'd1: begin dbl = {w, w} >> n; r = dbl[W2-1:0]; end
            2'd2: r = W2'($signed(w) >>> n);
            default: r = w << n;
        endcase
        e.d = (m == 2'd3) ? r[W2-1:DW] : r[DW-1:0];
        mask = (32'd1 << n) - 32'd1;
        e.s = 1'b0;
`ifdef FUNNEL_STICKY_EN
        e.s = (m == 2'd0 || m == 2'd2) && ((32'(w) & mask) != 0);
`endif
        return e;
    endfunction

    // Present one item from a negedge; returns at the negedge after accept.
    task automatic send(input logic [W2-1:0] w, input int n, input logic [1:0] m);
        int t = 0;
        in_valid = 1; in_data = w; in_shamt = SW'(n); in_mode = m;
        forever begin
            #4;
            if (in_ready && !flush && !rst) begin
                exp_q.push_back(model(w, n, m));
                @(negedge clk);
                break;
            end
            @(negedge clk);
            t++;
            if (t > 2000) begin
                $display("FAIL send_timeout: got stuck expected accept");
                $fatal(1, "send timeout");
            end
        end
    endtask

    task automatic idle(input int c);
        in_valid = 0;
        repeat (c) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    // Monitor: pop and compare on every handshake; check hold while stalled.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (rst || flush) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(held_data));
            end
            if (out_valid && !out_ready && !in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_sticky", 32'(sticky), 32'(e.s));
                    delivered++;
                end
            end
            prev_hold = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    initial begin
        int k;
        bit any;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sticky", 32'(sticky), 32'd0);
        @(negedge clk);

        // First item: latency of four cycles.
        send(16'hABCD, 12, 2'd0);
        in_valid = 0;
        k = 1;
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        chk("latency_first", k, 4);
        idle(6);

        // Back-to-back mixed modes, results on consecutive cycles.
        send(16'hABCD, 12, 2'd1);
        send(16'hABCD, 12, 2'd2);
        send(16'hABCD, 4, 2'd3);
        send(16'h1234, 0, 2'd0);
        in_valid = 0;
        wait_valid("b2b_first");
        for (int i = 0; i < 4; i++) begin
            chk("b2b_consec", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        send(16'h8000, 15, 2'd0);
        idle(8);
        chk("directed_drained", exp_q.size(), 0);

        // Six items with the consumer stalled for five cycles.
        k = delivered;
        saw_stall = 0;
        out_ready = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(W2'($urandom), $urandom_range(0, W2 - 1), 2'($urandom));
                in_valid = 0;
            end
            begin
                wait_valid("stall_valid");
                repeat (5) @(negedge clk);
                out_ready = 1;
            end
        join
        idle(10);
        chk("stall_seen", 32'(saw_stall), 32'd1);
        chk("stall_delivered", delivered - k, 6);

        // Three in flight, then flush (with a dropped input), then reset.
        send(16'h1111, 1, 2'd0);
        send(16'h2222, 2, 2'd1);
        send(16'h3333, 3, 2'd3);
        in_valid = 1; in_data = 16'hFFFF; in_shamt = 4'd5; in_mode = 2'd0;
        flush = 1;
        exp_q.delete();
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        flush = 0; in_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        any = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid) any = 1;
            @(negedge clk);
        end
        chk("purged_no_valid", 32'(any), 32'd0);
        send(16'hC3A5, 7, 2'd2);
        in_valid = 0;
        k = 1;
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        chk("latency_after_purge", k, 4);
        idle(6);

        // Randomised traffic with random backpressure.
        k = delivered;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    if ($urandom_range(0, 4) == 0) idle(1);
                    send(W2'($urandom), $urandom_range(0, W2 - 1), 2'($urandom));
                end
                in_valid = 0;
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        idle(4);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_delivered", delivered - k, 2000);

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
